// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: issues 2 (8086) or 3 (MCS-80/85) INTA pulses,
// captures the controller's bytes and presents the resolved vector with a valid/ready handshake.
module inta_sequencer #(
  parameter int PULSE_LOW_CYCLES = 2,
  parameter int PULSE_GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        interrupt_to_cpu,
  input  logic        interrupt_enable,
  input  logic        cpu_mode_8086,
  input  logic [7:0]  data_bus_in,
  input  logic        vector_ready,
  output logic        interrupt_acknowledge_n,
  output logic        busy,
  output logic        vector_valid,
  output logic [7:0]  vector_type,
  output logic [15:0] vector_address,
  output logic        call_opcode_error
);

  // state   | meaning
  // IDLE    | waiting for INT with interrupts enabled
  // ACK_LOW | INTA strobe held low, phase_cnt counts down the low time
  // ACK_GAP | INTA high between pulses, phase_cnt counts down the gap
  // DONE    | vector presented, waiting for vector_ready

  localparam logic [3:0] LOW_LOAD = 4'(PULSE_LOW_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD = 4'(PULSE_GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACK_LOW, ACK_GAP, DONE} state_t;

  state_t     state, state_d;
  logic [1:0] pulse_cnt, pulse_cnt_d;
  logic [3:0] phase_cnt, phase_cnt_d;
  logic       mode_8086, mode_8086_d;
  logic       capture;
  logic       start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= IDLE;
      pulse_cnt               <= 2'd0;
      phase_cnt               <= 4'd0;
      mode_8086               <= 1'b0;
      interrupt_acknowledge_n <= 1'b1;
    end else begin
      state                   <= state_d;
      pulse_cnt               <= pulse_cnt_d;
      phase_cnt               <= phase_cnt_d;
      mode_8086               <= mode_8086_d;
      // Strobe registered from the next state so it is glitch-free and lines up with ACK_LOW.
      interrupt_acknowledge_n <= (state_d != ACK_LOW);
    end
  end

  // pulse_cnt holds the number of pulses still to follow the current one.
  always_comb begin
    state_d     = state;
    pulse_cnt_d = pulse_cnt;
    phase_cnt_d = phase_cnt;
    mode_8086_d = mode_8086;
    capture     = 1'b0;
    start       = 1'b0;
    case (state)
      IDLE: begin
        if (interrupt_to_cpu && interrupt_enable) begin
          start       = 1'b1;
          state_d     = ACK_LOW;
          phase_cnt_d = LOW_LOAD;
          mode_8086_d = cpu_mode_8086;
          pulse_cnt_d = cpu_mode_8086 ? 2'd1 : 2'd2;
        end
      end
      ACK_LOW: begin
        if (phase_cnt == 4'd0) begin
          capture = 1'b1;
          if (pulse_cnt == 2'd0) begin
            state_d = DONE;
          end else begin
            state_d     = ACK_GAP;
            phase_cnt_d = GAP_LOAD;
            pulse_cnt_d = pulse_cnt - 2'd1;
          end
        end else begin
          phase_cnt_d = phase_cnt - 4'd1;
        end
      end
      ACK_GAP: begin
        if (phase_cnt == 4'd0) begin
          state_d     = ACK_LOW;
          phase_cnt_d = LOW_LOAD;
        end else begin
          phase_cnt_d = phase_cnt - 4'd1;
        end
      end
      DONE: begin
        if (vector_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte placement depends on which pulse is ending: MCS-80 pulses carry opcode, low, high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vector_type       <= 8'd0;
      vector_address    <= 16'd0;
      call_opcode_error <= 1'b0;
    end else if (start) begin
      vector_type       <= 8'd0;
      vector_address    <= 16'd0;
      call_opcode_error <= 1'b0;
    end else if (capture) begin
      if (mode_8086) begin
        if (pulse_cnt == 2'd0) begin
          vector_type       <= data_bus_in;
          vector_address    <= {6'b0, data_bus_in, 2'b00};
          call_opcode_error <= 1'b0;
        end
      end else begin
        case (pulse_cnt)
          2'd2: call_opcode_error <= (data_bus_in != 8'hCD);
          2'd1: begin
            vector_type         <= data_bus_in;
            vector_address[7:0] <= data_bus_in;
          end
          default: vector_address[15:8] <= data_bus_in;
        endcase
      end
    end
  end

  assign busy         = (state != IDLE);
  assign vector_valid = (state == DONE);

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: random and directed acknowledge sequences,
// a reference model of the vector decode, and pulse-shape monitoring.
module tb_inta_sequencer;

  localparam int LOW = 2;
  localparam int GAP = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        interrupt_to_cpu = 1'b0;
  logic        interrupt_enable = 1'b0;
  logic        cpu_mode_8086 = 1'b0;
  logic [7:0]  data_bus_in = 8'd0;
  logic        vector_ready = 1'b0;
  logic        interrupt_acknowledge_n;
  logic        busy;
  logic        vector_valid;
  logic [7:0]  vector_type;
  logic [15:0] vector_address;
  logic        call_opcode_error;

  typedef struct {
    logic [7:0]  vt;
    logic [15:0] va;
    logic        err;
    int          np;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] byte_q[$];
  int         checks = 0;
  int         errors = 0;
  int         seq_pulse = 0;
  int         low_run = 0;
  int         high_run = 0;
  logic       mon_prev = 1'b1;
  logic       drv_prev = 1'b1;
  logic [7:0] cur_byte = 8'd0;

  inta_sequencer #(.PULSE_LOW_CYCLES(LOW), .PULSE_GAP_CYCLES(GAP)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .interrupt_to_cpu       (interrupt_to_cpu),
    .interrupt_enable       (interrupt_enable),
    .cpu_mode_8086          (cpu_mode_8086),
    .data_bus_in            (data_bus_in),
    .vector_ready           (vector_ready),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .busy                   (busy),
    .vector_valid           (vector_valid),
    .vector_type            (vector_type),
    .vector_address         (vector_address),
    .call_opcode_error      (call_opcode_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference decode straight from the byte-level rules.
  function automatic exp_t model(input bit m8086, input logic [7:0] b1, input logic [7:0] b2,
                                 input logic [7:0] b3);
    exp_t e;
    e.vt = b2;
    if (m8086) begin
      e.va  = 16'(b2) * 16'd4;
      e.err = 1'b0;
      e.np  = 2;
    end else begin
      e.va  = 16'(b3) * 16'd256 + 16'(b2);
      e.err = (b1 != 8'hCD);
      e.np  = 3;
    end
    return e;
  endfunction

  task automatic push_txn(input bit m, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, output exp_t e);
    byte_q.push_back(b1);
    byte_q.push_back(b2);
    if (!m) byte_q.push_back(b3);
    e = model(m, b1, b2, b3);
    exp_q.push_back(e);
  endtask

  // how: 0 = random INT/EN/mode wiggle mid-sequence, 1 = drop INT/EN during pulse 1,
  //      2 = stall with INT high, then back-to-back start in mode next_m.
  task automatic run_seq(input bit m, input exp_t e, input bit started, input int how,
                         input bit next_m);
    int n;
    bit seen;
    if (!started) begin
      cpu_mode_8086    = m;
      interrupt_to_cpu = 1'b1;
      interrupt_enable = 1'b1;
      step();
      chk("start_latency", 32'(interrupt_acknowledge_n), 32'd0);
    end
    if (how == 1) begin
      interrupt_to_cpu = 1'b0;
      interrupt_enable = 1'b0;
    end else begin
      n = $urandom_range(0, 3);
      repeat (n) step();
      interrupt_to_cpu = 1'($urandom_range(0, 1));
      interrupt_enable = 1'($urandom_range(0, 1));
      cpu_mode_8086    = 1'($urandom_range(0, 1));
    end
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (vector_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("valid_timeout", 32'(seen), 32'd1);
    if (how == 2) begin
      interrupt_to_cpu = 1'b1;
      interrupt_enable = 1'b1;
      cpu_mode_8086    = next_m;
      for (int i = 0; i < 10; i++) begin
        chk("stall_valid", 32'(vector_valid), 32'd1);
        chk("stall_inta", 32'(interrupt_acknowledge_n), 32'd1);
        chk("stall_type", 32'(vector_type), 32'(e.vt));
        chk("stall_addr", 32'(vector_address), 32'(e.va));
        chk("stall_err", 32'(call_opcode_error), 32'(e.err));
        step();
      end
      vector_ready = 1'b1;
      step();
      vector_ready = 1'b0;
      chk("hs_valid_drop", 32'(vector_valid), 32'd0);
      chk("hs_no_start", 32'(interrupt_acknowledge_n), 32'd1);
      step();
      chk("b2b_start", 32'(interrupt_acknowledge_n), 32'd0);
    end else begin
      interrupt_to_cpu = 1'b0;
      n = $urandom_range(0, 3);
      repeat (n) begin
        chk("hold_valid", 32'(vector_valid), 32'd1);
        step();
      end
      vector_ready = 1'b1;
      step();
      vector_ready = 1'b0;
      chk("valid_drop", 32'(vector_valid), 32'd0);
    end
  endtask

  // Data driver: presents the next queued byte for the whole of each INTA low, garbage otherwise.
  initial begin
    forever begin
      @(negedge clock);
      if (!interrupt_acknowledge_n) begin
        if (drv_prev) cur_byte = (byte_q.size() > 0) ? byte_q.pop_front() : 8'($urandom);
        data_bus_in = cur_byte;
      end else begin
        data_bus_in = 8'($urandom);
      end
      drv_prev = interrupt_acknowledge_n;
    end
  end

  // Monitor: pulse widths, gaps, pulse counts and vector scoreboard on each handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (mon_prev && !interrupt_acknowledge_n) begin
        if (seq_pulse > 0 && busy) chk("gap_width", 32'(high_run), 32'(GAP));
        seq_pulse++;
        low_run = 1;
      end else if (!interrupt_acknowledge_n) begin
        low_run++;
      end
      if (!mon_prev && interrupt_acknowledge_n) begin
        if (busy) chk("low_width", 32'(low_run), 32'(LOW));
        high_run = 1;
      end else if (interrupt_acknowledge_n) begin
        high_run++;
      end
      if (vector_valid && vector_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vector: got type %0h with nothing expected", vector_type);
        end else begin
          e = exp_q.pop_front();
          chk("vector_type", 32'(vector_type), 32'(e.vt));
          chk("vector_address", 32'(vector_address), 32'(e.va));
          chk("call_opcode_error", 32'(call_opcode_error), 32'(e.err));
          chk("pulse_count", 32'(seq_pulse), 32'(e.np));
        end
      end
      if (!busy) seq_pulse = 0;
      mon_prev = interrupt_acknowledge_n;
    end
  end

  initial begin
    exp_t e, e2;
    bit m, m2, seen;
    logic [7:0] b1, b2, b3;

    repeat (3) step();
    chk("rst_inta", 32'(interrupt_acknowledge_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(vector_valid), 32'd0);
    chk("rst_type", 32'(vector_type), 32'd0);
    chk("rst_addr", 32'(vector_address), 32'd0);
    chk("rst_err", 32'(call_opcode_error), 32'd0);
    reset_n = 1'b1;
    step();

    push_txn(1'b1, 8'h5A, 8'hF8, 8'h00, e);
    run_seq(1'b1, e, 1'b0, 0, 1'b0);
    push_txn(1'b0, 8'hCD, 8'hE0, 8'hFF, e);
    run_seq(1'b0, e, 1'b0, 0, 1'b0);
    push_txn(1'b0, 8'h00, 8'h10, 8'h20, e);
    run_seq(1'b0, e, 1'b0, 0, 1'b0);

    push_txn(1'b0, 8'hCD, 8'h34, 8'h12, e);
    push_txn(1'b1, 8'h11, 8'h22, 8'h00, e2);
    run_seq(1'b0, e, 1'b0, 2, 1'b1);
    run_seq(1'b1, e2, 1'b1, 0, 1'b0);

    interrupt_enable = 1'b0;
    interrupt_to_cpu = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("disabled_busy", 32'(busy), 32'd0);
      chk("disabled_inta", 32'(interrupt_acknowledge_n), 32'd1);
    end
    interrupt_to_cpu = 1'b0;
    step();

    push_txn(1'b0, 8'hCD, 8'hAA, 8'hBB, e);
    run_seq(1'b0, e, 1'b0, 1, 1'b0);

    byte_q.push_back(8'h00);
    byte_q.push_back(8'h44);
    byte_q.push_back(8'h55);
    cpu_mode_8086    = 1'b0;
    interrupt_to_cpu = 1'b1;
    interrupt_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (seq_pulse == 2 && !interrupt_acknowledge_n) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reach_pulse2", 32'(seen), 32'd1);
    interrupt_to_cpu = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_inta", 32'(interrupt_acknowledge_n), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(vector_valid), 32'd0);
    chk("midrst_type", 32'(vector_type), 32'd0);
    chk("midrst_addr", 32'(vector_address), 32'd0);
    chk("midrst_err", 32'(call_opcode_error), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    byte_q.delete();
    step();
    push_txn(1'b1, 8'h01, 8'h3C, 8'h00, e);
    run_seq(1'b1, e, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      m  = 1'($urandom_range(0, 1));
      b1 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hCD;
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      push_txn(m, b1, b2, b3, e);
      if (k % 9 == 4) begin
        m2 = 1'($urandom_range(0, 1));
        push_txn(m2, 8'hCD, 8'($urandom), 8'($urandom), e2);
        run_seq(m, e, 1'b0, 2, m2);
        run_seq(m2, e2, 1'b1, 0, 1'b0);
      end else begin
        run_seq(m, e, 1'b0, (k % 5 == 2) ? 1 : 0, 1'b0);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (5) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
